// File: rtl/if_fetch.sv
// Instruction fetch front end: sequential PC issue to a 1-cycle memory, 2-entry
// instruction queue with bypass of the returning word, and redirect flush.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_rd,
  output logic [11:2] im_addr,
  input  logic [31:0] im_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  typedef enum logic {BOOT, RUN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q;
  logic               inflight_q;
  logic [31:0]        inflight_pc_q;
  logic [31:0]        fifo_inst_q [DEPTH];
  logic [31:0]        fifo_pc_q   [DEPTH];
  logic               rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               fifo_empty;
  logic               resp_show;
  logic               pop;
  logic               fifo_pop;
  logic               push;
  logic [OCC_W-1:0]   occ;
  logic [31:0]        target_pc;

  assign im_addr   = pc_q[11:2];
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  // Next state plus the combinational handshake: queue head, issue and push decisions.
  always_comb begin
    state_d    = state_q;
    fifo_empty = (count_q == CNT_W'(0));
    resp_show  = 1'b0;
    inst_valid = 1'b0;
    inst       = 32'h0;
    inst_pc    = 32'h0;
    pop        = 1'b0;
    fifo_pop   = 1'b0;
    push       = 1'b0;
    im_rd      = 1'b0;
    occ        = OCC_W'(count_q) + OCC_W'(inflight_q);

    case (state_q)
      BOOT:    state_d = RUN;
      default: state_d = RUN;
    endcase

    // A word arriving in a redirect cycle belongs to the old path and is never shown.
    resp_show  = inflight_q && !redirect;
    inst_valid = !rst && (!fifo_empty || resp_show);
    if (inst_valid) begin
      inst    = fifo_empty ? im_dout       : fifo_inst_q[rd_ptr_q];
      inst_pc = fifo_empty ? inflight_pc_q : fifo_pc_q[rd_ptr_q];
    end

    pop      = inst_valid && inst_ready;
    fifo_pop = pop && !fifo_empty;
    push     = !rst && !redirect && inflight_q && !(pop && fifo_empty);
    im_rd    = !rst && (state_q == RUN) && !redirect &&
               (occ < (OCC_W'(2) + OCC_W'(pop)));
  end

  // Control state: FSM, PC, in-flight tag and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= im_rd;
      if (im_rd) inflight_pc_q <= pc_q;
      if (redirect) begin
        pc_q     <= target_pc;
        count_q  <= '0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (im_rd)    pc_q     <= pc_q + 32'd4;
        if (push)     wr_ptr_q <= !wr_ptr_q;
        if (fifo_pop) rd_ptr_q <= !rd_ptr_q;
        count_q <= count_q + CNT_W'(push) - CNT_W'(fifo_pop);
      end
    end
  end

  // Queue storage; contents are only observed while the count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= im_dout;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule
